// File: rtl/codon_histogram_display.sv
// Codon tally: one saturating counter per codon value plus a saturating total,
// with a registered LED view of a selected bin or the total once the sequence ends.
module codon_histogram_display #(
  parameter int SYMBOL_W = 4,
  parameter int NUM_BINS = 8,
  parameter int COUNT_W  = 8,
  parameter int SEL_W    = 3,
  parameter int LED_W    = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [SYMBOL_W-1:0] codon_in,
  input  logic                codon_valid,
  input  logic                codon_last,
  output logic                codon_ready,
  input  logic [SEL_W-1:0]    switches,
  input  logic                mode,
  output logic [LED_W-1:0]    leds,
  output logic                done,
  output logic                overflow
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [COUNT_W-1:0]  COUNT_MAX   = {COUNT_W{1'b1}};
  localparam logic [SYMBOL_W:0]   NUM_BINS_CW = (SYMBOL_W + 1)'(NUM_BINS);
  localparam logic [SEL_W:0]      NUM_BINS_SW = (SEL_W + 1)'(NUM_BINS);
  localparam int                  CMP_W       = (COUNT_W > LED_W) ? COUNT_W : LED_W;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    sat_inc = (v == COUNT_MAX) ? v : v + COUNT_W'(1'b1);
  endfunction

  // Clamp a counter value to what the LEDs can show; larger values light every LED.
  function automatic logic [LED_W-1:0] disp_sat(input logic [COUNT_W-1:0] v);
    logic [CMP_W-1:0] v_ext;
    v_ext = CMP_W'(v);
    if (v_ext > CMP_W'({LED_W{1'b1}})) begin
      disp_sat = {LED_W{1'b1}};
    end else begin
      disp_sat = LED_W'(v_ext);
    end
  endfunction

  state_t               state_r, state_nxt_s;
  logic [COUNT_W-1:0]   bins_r [NUM_BINS];
  logic [COUNT_W-1:0]   bins_nxt_s [NUM_BINS];
  logic [COUNT_W-1:0]   total_r, total_nxt_s;
  logic                 overflow_r, overflow_nxt_s;
  logic                 ready_r, done_r;
  logic [LED_W-1:0]     leds_r;
  logic                 beat_s, clear_s, in_range_s, bin_full_s, sel_in_range_s;
  logic [COUNT_W-1:0]   sel_bin_s, disp_val_s;

  assign beat_s         = codon_valid & ready_r;
  assign clear_s        = start & (state_r != ST_COUNT);
  assign in_range_s     = ({1'b0, codon_in} < NUM_BINS_CW);
  assign sel_in_range_s = ({1'b0, switches} < NUM_BINS_SW);

  // Next-state logic; start is only honoured outside COUNT.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_COUNT;
        else       state_nxt_s = ST_IDLE;
      end
      ST_COUNT: begin
        if (beat_s && codon_last) state_nxt_s = ST_DONE;
        else                      state_nxt_s = ST_COUNT;
      end
      ST_DONE: begin
        if (start) state_nxt_s = ST_COUNT;
        else       state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Bin lookups: saturation of the addressed bin and the bin chosen for display.
  always_comb begin
    bin_full_s = 1'b0;
    sel_bin_s  = {COUNT_W{1'b0}};
    for (int i = 0; i < NUM_BINS; i++) begin
      bin_full_s = bin_full_s |
                   ((codon_in == i[SYMBOL_W-1:0]) && (bins_r[i] == COUNT_MAX));
      sel_bin_s  = sel_bin_s |
                   ({COUNT_W{switches == i[SEL_W-1:0]}} & bins_r[i]);
    end
  end

  // Counter next values: start clears, an accepted beat bumps its bin and the total.
  always_comb begin
    total_nxt_s    = total_r;
    overflow_nxt_s = overflow_r;
    for (int i = 0; i < NUM_BINS; i++) begin
      bins_nxt_s[i] = bins_r[i];
    end
    if (clear_s) begin
      total_nxt_s    = {COUNT_W{1'b0}};
      overflow_nxt_s = 1'b0;
      for (int i = 0; i < NUM_BINS; i++) begin
        bins_nxt_s[i] = {COUNT_W{1'b0}};
      end
    end else if (beat_s) begin
      total_nxt_s    = sat_inc(total_r);
      overflow_nxt_s = overflow_r | (total_r == COUNT_MAX) | ~in_range_s | bin_full_s;
      for (int i = 0; i < NUM_BINS; i++) begin
        bins_nxt_s[i] = (codon_in == i[SYMBOL_W-1:0]) ? sat_inc(bins_r[i]) : bins_r[i];
      end
    end else begin
      total_nxt_s = total_r;
    end
  end

  // Display source: total, selected bin, or zero for an unused switch setting.
  always_comb begin
    disp_val_s = {COUNT_W{1'b0}};
    if (mode) begin
      disp_val_s = total_r;
    end else if (sel_in_range_s) begin
      disp_val_s = sel_bin_s;
    end else begin
      disp_val_s = {COUNT_W{1'b0}};
    end
  end

  // State, handshake and status registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      ready_r    <= 1'b0;
      done_r     <= 1'b0;
      total_r    <= {COUNT_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      ready_r    <= (state_nxt_s == ST_COUNT);
      done_r     <= (state_nxt_s == ST_DONE);
      total_r    <= total_nxt_s;
      overflow_r <= overflow_nxt_s;
    end
  end

  // Bin counter registers.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_BINS; i++) begin
      if (reset) bins_r[i] <= {COUNT_W{1'b0}};
      else       bins_r[i] <= bins_nxt_s[i];
    end
  end

  // LED register: blank until the sequence is complete.
  always_ff @(posedge clock) begin
    if (reset) begin
      leds_r <= {LED_W{1'b0}};
    end else if (state_r == ST_DONE) begin
      leds_r <= disp_sat(disp_val_s);
    end else begin
      leds_r <= {LED_W{1'b0}};
    end
  end

  assign codon_ready = ready_r;
  assign done        = done_r;
  assign overflow    = overflow_r;
  assign leds        = leds_r;

endmodule

// File: tb/tb_codon_histogram_display.sv
// Directed bench for codon_histogram_display: a cycle table for the basic sequence
// plus hand-written sequences for saturation, out-of-range codons, handshake and reset.
module tb_codon_histogram_display;

  logic       clock = 1'b0;
  logic       reset, start, codon_valid, codon_last, mode;
  logic [3:0] codon_in;
  logic [2:0] switches;
  logic       codon_ready, done, overflow;
  logic [3:0] leds;
  logic       codon_ready4, done4, overflow4;
  logic [4:0] leds4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  codon_histogram_display dut (
    .clock(clock), .reset(reset), .start(start), .codon_in(codon_in),
    .codon_valid(codon_valid), .codon_last(codon_last), .codon_ready(codon_ready),
    .switches(switches), .mode(mode), .leds(leds), .done(done), .overflow(overflow)
  );

  // Narrow-counter variant with one extra LED so a count of 15 is distinguishable.
  codon_histogram_display #(.COUNT_W(4), .LED_W(5)) dut4 (
    .clock(clock), .reset(reset), .start(start), .codon_in(codon_in),
    .codon_valid(codon_valid), .codon_last(codon_last), .codon_ready(codon_ready4),
    .switches(switches), .mode(mode), .leds(leds4), .done(done4), .overflow(overflow4)
  );

  typedef struct {
    logic       st;
    logic       vl;
    logic [3:0] cd;
    logic       ls;
    logic [2:0] sw;
    logic       md;
    logic       e_rdy;
    logic       e_done;
    logic [3:0] e_leds;
    logic       e_ovf;
  } vec_t;

  vec_t tbl [9];

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs;
    start = 1'b0; codon_valid = 1'b0; codon_last = 1'b0; codon_in = 4'd0;
  endtask

  task automatic beat(input logic [3:0] c, input logic l);
    codon_valid = 1'b1; codon_in = c; codon_last = l;
    tick();
    codon_valid = 1'b0; codon_last = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic show(input logic [2:0] sw, input logic md);
    switches = sw; mode = md;
    tick();
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 4'd1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 4'd1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 4'd3, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 4'd1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 4'd0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 4'd0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 4'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 4'd4, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 4'd0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0};

    idle_inputs(); switches = 3'd0; mode = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("reset ready", codon_ready, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset leds", leds, 4'd0);
    chk("reset ovf", overflow, 1'b0);

    // Basic sequence 1,1,3,1(last) and display readback, one table row per cycle.
    for (int i = 0; i < 9; i++) begin
      start = tbl[i].st; codon_valid = tbl[i].vl; codon_in = tbl[i].cd;
      codon_last = tbl[i].ls; switches = tbl[i].sw; mode = tbl[i].md;
      tick();
      chk($sformatf("tbl%0d ready", i), codon_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d done", i), done, tbl[i].e_done);
      chk($sformatf("tbl%0d leds", i), leds, tbl[i].e_leds);
      chk($sformatf("tbl%0d ovf", i), overflow, tbl[i].e_ovf);
    end
    idle_inputs();

    // Twenty codons of 2: bin count 20 shows as all ones on four LEDs.
    pulse_start();
    chk("restart done drops", done, 1'b0);
    chk("restart ready", codon_ready, 1'b1);
    for (int i = 0; i < 20; i++) beat(4'd2, (i == 19) ? 1'b1 : 1'b0);
    chk("seq20 done", done, 1'b1);
    show(3'd2, 1'b0);
    chk("seq20 bin2 leds", leds, 4'd15);
    show(3'd1, 1'b0);
    chk("seq20 bin1 leds", leds, 4'd0);
    chk("seq20 ovf", overflow, 1'b0);

    // Seventeen codons of 0: the 4-bit-counter variant saturates at 15.
    pulse_start();
    for (int i = 0; i < 17; i++) beat(4'd0, (i == 16) ? 1'b1 : 1'b0);
    show(3'd0, 1'b0);
    chk("sat4 bin0 leds", leds4, 5'd15);
    chk("sat8 bin0 leds", leds, 4'd15);
    show(3'd0, 1'b1);
    chk("sat4 total leds", leds4, 5'd15);
    chk("sat4 ovf", overflow4, 1'b1);
    chk("sat8 ovf", overflow, 1'b0);

    // Out-of-range codon 9 counts toward the total only and flags overflow.
    pulse_start();
    chk("start clears ovf4", overflow4, 1'b0);
    beat(4'd9, 1'b0);
    beat(4'd0, 1'b1);
    show(3'd0, 1'b1);
    chk("oor total", leds, 4'd2);
    show(3'd0, 1'b0);
    chk("oor bin0", leds, 4'd1);
    show(3'd1, 1'b0);
    chk("oor bin1", leds, 4'd0);
    chk("oor ovf", overflow, 1'b1);

    // Handshake: valid held in IDLE is not counted; start mid-COUNT is ignored.
    reset = 1'b1; tick(); reset = 1'b0;
    codon_valid = 1'b1; codon_in = 4'd4;
    tick(); tick();
    chk("idle ready low", codon_ready, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    chk("hs ready", codon_ready, 1'b1);
    codon_valid = 1'b1; tick();
    codon_valid = 1'b0; tick();
    codon_valid = 1'b1; start = 1'b1; tick();
    start = 1'b0; codon_valid = 1'b0; tick();
    chk("start in count ignored", codon_ready, 1'b1);
    beat(4'd5, 1'b1);
    chk("hs done", done, 1'b1);
    show(3'd4, 1'b0);
    chk("hs bin4", leds, 4'd2);
    show(3'd5, 1'b0);
    chk("hs bin5", leds, 4'd1);
    show(3'd0, 1'b1);
    chk("hs total", leds, 4'd3);
    pulse_start();
    chk("done start drops done", done, 1'b0);
    tick();
    chk("count leds blank", leds, 4'd0);
    beat(4'd6, 1'b1);
    show(3'd0, 1'b1);
    chk("cleared total", leds, 4'd1);

    // Reset in the middle of a sequence drops the beat presented with it.
    pulse_start();
    for (int i = 0; i < 3; i++) beat(4'd1, 1'b0);
    reset = 1'b1; codon_valid = 1'b1; codon_in = 4'd1;
    tick();
    reset = 1'b0; codon_valid = 1'b0;
    chk("mid reset ready", codon_ready, 1'b0);
    chk("mid reset done", done, 1'b0);
    chk("mid reset leds", leds, 4'd0);
    chk("mid reset ovf", overflow, 1'b0);
    beat(4'd1, 1'b1);
    chk("after reset no accept", done, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
